// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the counter sequencer and its watchdog.
package counter_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    // The tick that ends a period depends on the captured count direction.
    function automatic logic terminal_sel(input logic dir, input logic max_tick, input logic min_tick);
        return (dir == DIR_UP) ? max_tick : min_tick;
    endfunction

endpackage

// File: rtl/counter_seq_watchdog.sv
// Counts consecutive RUN cycles without a terminal tick; expires on the (2^N+1)-th.
// Only instantiated when COUNTER_SEQ_TIMEOUT_EN is defined.
module counter_seq_watchdog #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic restart,
    output logic expired
);

    localparam logic [N:0] LIMIT = {1'b1, {N{1'b0}}};

    logic [N:0] count_r;

    // Count non-terminal RUN cycles; saturates at the limit until the next reload.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {(N+1){1'b0}};
        end else if (restart) begin
            count_r <= {(N+1){1'b0}};
        end else if (run && (count_r != LIMIT)) begin
            count_r <= count_r + {{N{1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = run && (count_r == LIMIT);

endmodule

// File: rtl/counter_sequencer.sv
// Sequences an N-bit binary counter through clear -> load -> run, one-shot or periodic.
// Optional RUN watchdog enabled by defining COUNTER_SEQ_TIMEOUT_EN.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int N = 4,
    parameter int P = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_up,
    input  logic         cmd_periodic,
    input  logic [N-1:0] cmd_value,
    input  logic         stop,
    output logic         syncClear,
    output logic         load,
    output logic [N-1:0] loadValue,
    output logic         enable,
    output logic         upCount,
    input  logic         maxTick,
    input  logic         minTick,
    output logic         busy,
    output logic         done,
    output logic         period_tick,
    output logic [P-1:0] period_cnt,
    output logic         timeout_err
);

    seq_state_t   state_r;
    logic         dir_r;
    logic         periodic_r;
    logic [N-1:0] value_r;
    logic [P-1:0] period_cnt_r;
    logic         cmd_ready_r;
    logic         busy_r;
    logic         sync_clear_r;
    logic         load_r;
    logic         done_r;
    logic         up_count_r;

    logic         in_run_s;
    logic         terminal_s;
    logic         expired_s;
    logic         to_idle_s;

    assign in_run_s   = (state_r == RUN);
    assign terminal_s = terminal_sel(dir_r, maxTick, minTick);

`ifdef COUNTER_SEQ_TIMEOUT_EN
    logic wd_expired_s;

    counter_seq_watchdog #(.N(N)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .run     (in_run_s && !terminal_s),
        .restart (state_r == LOAD),
        .expired (wd_expired_s)
    );

    assign expired_s   = wd_expired_s;
    assign timeout_err = wd_expired_s && !stop;
`else
    assign expired_s   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Stop wins over a same-cycle terminal; DONE always falls back to IDLE.
    assign to_idle_s = (state_r == DONE)
                     || (stop && ((state_r == CLEAR) || (state_r == LOAD) || (state_r == RUN)))
                     || expired_s;

    // Sequencer FSM with registered strobes and captured command.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            dir_r        <= DIR_DOWN;
            periodic_r   <= 1'b0;
            value_r      <= {N{1'b0}};
            period_cnt_r <= {P{1'b0}};
            cmd_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            sync_clear_r <= 1'b0;
            load_r       <= 1'b0;
            done_r       <= 1'b0;
            up_count_r   <= 1'b0;
        end else begin
            sync_clear_r <= 1'b0;
            load_r       <= 1'b0;
            done_r       <= 1'b0;
            if (to_idle_s) begin
                state_r     <= IDLE;
                cmd_ready_r <= 1'b1;
                busy_r      <= 1'b0;
                up_count_r  <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (cmd_valid) begin
                            dir_r        <= cmd_up;
                            periodic_r   <= cmd_periodic;
                            value_r      <= cmd_value;
                            period_cnt_r <= {P{1'b0}};
                            up_count_r   <= cmd_up;
                            cmd_ready_r  <= 1'b0;
                            busy_r       <= 1'b1;
                            sync_clear_r <= 1'b1;
                            state_r      <= CLEAR;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    CLEAR: begin
                        load_r  <= 1'b1;
                        state_r <= LOAD;
                    end
                    LOAD: begin
                        state_r <= RUN;
                    end
                    RUN: begin
                        if (terminal_s) begin
                            period_cnt_r <= period_cnt_r + {{(P-1){1'b0}}, 1'b1};
                            if (periodic_r) begin
                                load_r  <= 1'b1;
                                state_r <= LOAD;
                            end else begin
                                done_r  <= 1'b1;
                                state_r <= DONE;
                            end
                        end else begin
                            state_r <= RUN;
                        end
                    end
                    default: begin
                        state_r     <= IDLE;
                        cmd_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        up_count_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cmd_ready   = cmd_ready_r;
    assign busy        = busy_r;
    assign syncClear   = sync_clear_r;
    assign load        = load_r;
    assign done        = done_r;
    assign loadValue   = value_r;
    assign upCount     = up_count_r;
    assign period_cnt  = period_cnt_r;
    // The counter must freeze on its terminal value and on any abort.
    assign enable      = in_run_s && !terminal_s && !stop && !expired_s;
    assign period_tick = in_run_s && terminal_s && !stop;

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench: behavioural counter environment plus a phase-arithmetic reference model.
module tb_counter_sequencer;

    localparam int N    = 4;
    localparam int P    = 8;
    localparam int MAXV = (1 << N) - 1;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic         cmd_up = 1'b0;
    logic         cmd_periodic = 1'b0;
    logic [N-1:0] cmd_value = '0;
    logic         stop = 1'b0;
    logic         syncClear, load, enable, upCount, maxTick, minTick;
    logic [N-1:0] loadValue;
    logic         busy, done, period_tick, timeout_err;
    logic [P-1:0] period_cnt;

    logic [N-1:0] env_cnt = '0;
    logic         force_low = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    counter_sequencer #(.N(N), .P(P)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_up(cmd_up), .cmd_periodic(cmd_periodic), .cmd_value(cmd_value), .stop(stop),
        .syncClear(syncClear), .load(load), .loadValue(loadValue), .enable(enable),
        .upCount(upCount), .maxTick(maxTick), .minTick(minTick), .busy(busy), .done(done),
        .period_tick(period_tick), .period_cnt(period_cnt), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Attached N-bit counter.
    always @(posedge clk) begin
        if (syncClear)   env_cnt <= '0;
        else if (load)   env_cnt <= loadValue;
        else if (enable) env_cnt <= upCount ? env_cnt + 1'b1 : env_cnt - 1'b1;
    end
    assign maxTick = !force_low && (env_cnt == MAXV[N-1:0]);
    assign minTick = !force_low && (env_cnt == '0);

    // Reference model: position k within an accepted sequence (k=1 is the clear cycle).
    bit m_active, m_dir, m_per;
    int m_k, m_val, m_pcnt;
    bit o_clr, o_ld, o_done, o_ready, o_max;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_dir = 0; m_per = 0; m_k = 0; m_val = 0; m_pcnt = 0;
    endtask

    // One clock cycle: drive, predict, compare at negedge, advance model at posedge.
    task automatic step(input bit v, input bit up, input bit per, input int val, input bit stp);
        int s, m, ph;
        bit term;
        cmd_valid = v; cmd_up = up; cmd_periodic = per; cmd_value = val[N-1:0]; stop = stp;
        s = m_dir ? (MAXV - m_val) : m_val;
        ph = 0; term = 0;
        if (m_active) begin
            if (m_k == 1) ph = 1;
            else if (m_per) begin
                m = (m_k - 2) % (s + 2);
                ph = (m == 0) ? 2 : 3;
                term = (m == s + 1);
            end else if (m_k == 2) ph = 2;
            else if (m_k <= 3 + s) begin
                ph = 3;
                term = (m_k == 3 + s);
            end else ph = 4;
        end
        @(negedge clk);
        o_clr = syncClear; o_ld = load; o_done = done; o_ready = cmd_ready; o_max = maxTick;
        check_eq("cmd_ready", cmd_ready, !m_active);
        check_eq("busy", busy, m_active);
        check_eq("syncClear", syncClear, ph == 1);
        check_eq("load", load, ph == 2);
        check_eq("done", done, ph == 4);
        check_eq("upCount", upCount, m_active ? m_dir : 1'b0);
        check_eq("loadValue", loadValue, m_val);
        check_eq("enable", enable, (ph == 3) && !term && !stp);
        check_eq("period_tick", period_tick, term && !stp);
        check_eq("period_cnt", period_cnt, m_pcnt);
        check_eq("timeout_err", timeout_err, 0);
        @(posedge clk);
        if (!m_active) begin
            if (v) begin
                m_active = 1; m_k = 1; m_dir = up; m_per = per; m_val = val % (MAXV + 1); m_pcnt = 0;
            end
        end else begin
            if (term && !stp) m_pcnt = (m_pcnt + 1) % (1 << P);
            if (stp && ph >= 1 && ph <= 3) m_active = 0;
            else if (ph == 4) m_active = 0;
            else m_k++;
        end
        #1;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_enable", enable, 0);
        check_eq("rst_period_cnt", period_cnt, 0);
        check_eq("rst_strobes", {syncClear, load, done, upCount, period_tick, timeout_err}, 0);
        check_eq("rst_loadValue", loadValue, 0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sc, lc, mc, dc, rc;
        model_reset();
        #12;
        check_eq("por_cmd_ready", cmd_ready, 1);
        check_eq("por_busy", busy, 0);
        check_eq("por_outputs", {syncClear, load, enable, done, upCount, period_tick, timeout_err}, 0);
        check_eq("por_period_cnt", period_cnt, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // One-shot up from 0: fixed latency milestones.
        step(1, 1, 0, 0, 0);
        sc = -1; lc = -1; mc = -1; dc = -1; rc = -1;
        for (int c = 1; c <= 20; c++) begin
            step(0, 0, 0, 0, 0);
            if (o_clr && sc < 0)   sc = c;
            if (o_ld && lc < 0)    lc = c;
            if (o_max && mc < 0 && c > 2) mc = c;
            if (o_done && dc < 0)  dc = c;
            if (o_ready && rc < 0) rc = c;
        end
        check_eq("lat_syncClear", sc, 1);
        check_eq("lat_load", lc, 2);
        check_eq("lat_maxTick", mc, 18);
        check_eq("lat_done", dc, 19);
        check_eq("lat_ready", rc, 20);
        check_eq("oneshot_pcnt", period_cnt, 1);

        // One-shot down from 15 with a held request that is only taken once idle again.
        step(1, 0, 0, 15, 0);
        for (int i = 0; i < 19; i++) step(1, 1, 0, 7, 0);
        step(1, 1, 0, 7, 0);
        idle_steps(14);

        // Periodic up from 12, then asynchronous reset mid-RUN.
        step(1, 1, 1, 12, 0);
        idle_steps(18);
        check_eq("periodic_pcnt", period_cnt, 3);
        idle_steps(2);
        #2;
        apply_reset();

        // Stop mid-RUN, and stop on the exact terminal cycle (one-shot and periodic).
        step(1, 1, 0, 0, 0);
        idle_steps(8);
        step(0, 0, 0, 0, 1);
        idle_steps(2);
        step(1, 1, 0, 13, 0);
        idle_steps(4);
        step(0, 0, 0, 0, 1);
        idle_steps(2);
        step(1, 0, 1, 2, 0);
        idle_steps(8);
        step(0, 0, 0, 0, 1);
        idle_steps(2);
        step(1, 0, 0, 0, 0);
        idle_steps(5);

        // Counter never reaches terminal: watchdog behaviour.
        force_low = 1'b1;
        cmd_valid = 1'b1; cmd_up = 1'b1; cmd_periodic = 1'b0; cmd_value = '0; stop = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
`ifdef COUNTER_SEQ_TIMEOUT_EN
            check_eq("wd_timeout_err", timeout_err, c == 19);
            check_eq("wd_enable", enable, (c >= 3) && (c <= 18));
            check_eq("wd_busy", busy, c <= 19);
`else
            check_eq("wd_timeout_err", timeout_err, 0);
            check_eq("wd_enable", enable, c >= 3);
            check_eq("wd_busy", busy, 1);
`endif
            @(posedge clk);
            #1;
        end
        stop = 1'b1;
        @(negedge clk);
        check_eq("wd_stop_enable", enable, 0);
        @(posedge clk);
        #1;
        stop = 1'b0;
        @(negedge clk);
        check_eq("wd_final_idle", cmd_ready, 1);
        force_low = 1'b0;
        apply_reset();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, MAXV), $urandom_range(0, 15) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Control stage directly upstream of the generic N-bit binary counter.
- Drives the counter's syncClear, load, loadValue, enable and upCount inputs, and consumes its maxTick and minTick outputs.
- Turns a single command handshake into a clear → load → run sequence, in one-shot or periodic (auto-reload) mode.
- Reports completion, per-period ticks and a completed-period count back to the system.

Parameters:
- N, 4, counter width; must match the attached counter.
- P, 8, width of the completed-period counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE.
- cmd_up  input  1  1 = count up (terminal = maxTick); 0 = count down (terminal = minTick).
- cmd_periodic  input  1  1 = reload and repeat after each terminal; 0 = one-shot.
- cmd_value  input  N  start value loaded into the counter.
- stop  input  1  abort request, level-sampled.
- syncClear  output  1  to counter.
- load  output  1  to counter.
- loadValue  output  N  to counter.
- enable  output  1  to counter.
- upCount  output  1  to counter.
- maxTick  input  1  from counter.
- minTick  input  1  from counter.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at one-shot completion.
- period_tick  output  1  one-cycle pulse on every terminal tick.
- period_cnt  output  P  completed periods since the last accepted command; wraps modulo 2^P.
- timeout_err  output  1  one-cycle pulse; see Optional Feature.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE; all outputs 0 except cmd_ready=1.
  - Captured command registers and period_cnt cleared.
  - Reset asserted mid-sequence aborts immediately, with no done pulse.
- States: IDLE, CLEAR, LOAD, RUN, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid=1, capture cmd_up, cmd_periodic and cmd_value, clear period_cnt, and go to CLEAR.
  - cmd_valid outside IDLE is ignored and never queued.
- CLEAR (1 cycle): syncClear=1, then LOAD.
- LOAD (1 cycle): load=1, loadValue=captured value, then RUN.
- RUN:
  - upCount = captured direction.
  - terminal = captured direction ? maxTick : minTick.
  - enable = !terminal && !stop (combinational), so the counter holds at its terminal value.
  - On terminal: period_tick=1 and period_cnt increments in the same cycle.
  - After terminal, one-shot goes to DONE; periodic goes to LOAD, giving a period of (steps to terminal)+2 cycles.
- DONE (1 cycle): done=1, then IDLE.
- loadValue holds the captured value outside LOAD; upCount holds the captured direction in all non-IDLE states and is 0 in IDLE.
- stop=1 in CLEAR, LOAD or RUN: next state IDLE, no done. If terminal occurs in the same cycle, stop wins: no period_tick, no increment.
- stop in IDLE or DONE has no effect.
- Start value already at terminal: RUN terminates in its first cycle (zero steps).
- Latency, one-shot up from 0 with N=4, cycle 0 = acceptance:
  - syncClear in cycle 1, load in cycle 2.
  - RUN cycles 3..18; maxTick in cycle 18.
  - done in cycle 19; cmd_ready=1 again in cycle 20.

Optional Feature:
- Macro COUNTER_SEQ_TIMEOUT_EN.
- Defined: a watchdog counts consecutive RUN cycles without terminal. On reaching 2^N+1, it pulses timeout_err for one cycle, drops enable and goes to IDLE with no done. The watchdog clears on entry to LOAD.
- Undefined: no watchdog logic; timeout_err is tied to 0.

Decomposition:
- Package counter_seq_pkg:
  - state enum typedef seq_state_t (IDLE, CLEAR, LOAD, RUN, DONE).
  - direction constants DIR_DOWN=0, DIR_UP=1.
- One natural sub-module, counter_seq_watchdog:
  - parameterised by N.
  - inputs: run, restart.
  - output: expired.
  - instantiated only under COUNTER_SEQ_TIMEOUT_EN.

Test Plan:
- One-shot up, value 0, N=4: cmd accepted cycle 0 → syncClear cycle 1, load cycle 2, maxTick cycle 18, done cycle 19, period_cnt=1, cmd_ready cycle 20.
- One-shot down, value 4'b1111 → 15 enabled RUN cycles, minTick, single done; then a second command at value 4'b0111 up → 8 steps to maxTick, done.
- Periodic up, value 4'b1100 → period_tick every 5 cycles; after 3 ticks period_cnt=3; load pulses between periods; no done.
- stop asserted mid-RUN and on the exact terminal cycle → IDLE next cycle, no done, no period_tick on the terminal cycle, enable=0 the same cycle.
- cmd_valid held while busy → ignored; reset=0 mid-RUN → outputs cleared asynchronously, cmd_ready=1, period_cnt=0.
- With COUNTER_SEQ_TIMEOUT_EN and maxTick forced low → timeout_err pulse after 17 RUN cycles, return to IDLE; without the macro, timeout_err stays 0.
